pin_change_capture: RTL and testbench

- Upstream stage of the SPI readout block: samples the monitored pins, detects value changes and timestamps each change with a free-running cycle counter.
- Buffers each {pins, timestamp} event in a first-word-fall-through FIFO.
- The SPI transmitter pops events through a valid/ready handshake and serialises them as pin byte then timestamp, MSB first.
- When the FIFO is empty, the transmitter reports live pins plus the `now` value.

---
 rtl/pin_change_capture.sv | 107 ++++++++++
 tb/tb_pin_change_capture.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pin_change_capture.sv
// Pin change capture: synchronises monitored pins, timestamps every value change
// and queues {pins, timestamp} events in a first-word-fall-through FIFO.
module pin_change_capture #(
    parameter int WIDTH       = 8,
    parameter int TS_WIDTH    = 32,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         pin_values,
    output logic [WIDTH-1:0]         ev_pins,
    output logic [TS_WIDTH-1:0]      ev_time,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clear_overflow,
    output logic [TS_WIDTH-1:0]      now,
    output logic [WIDTH-1:0]         live_pins
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = WIDTH + TS_WIDTH;

    localparam logic [AW:0]         CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]         CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]       PTR_ONE  = AW'(1);
    localparam logic [TS_WIDTH-1:0] TS_ONE   = TS_WIDTH'(1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] last_pins;
    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    logic change;
    logic full;
    logic push;
    logic pop;
    logic drop;

    // Synchroniser chain for the asynchronous pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pin_values;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign live_pins = sync_q[SYNC_STAGES-1];

    // Handshake: the head on ev_pins/ev_time is consumed on a rising edge where
    // ev_valid && ev_ready; ev_ready is ignored while ev_valid is low, and
    // ev_valid/ev_pins/ev_time never depend combinationally on ev_ready.
    assign ev_valid = (count != '0);
    assign full     = (count == CNT_FULL);
    assign change   = (live_pins != last_pins);
    assign pop      = ev_valid && ev_ready;
    assign push     = change && (!full || pop);
    assign drop     = change && full && !pop;

    assign ev_pins  = mem[rptr][EW-1:TS_WIDTH];
    assign ev_time  = mem[rptr][TS_WIDTH-1:0];

    // Free-running timestamp; wraps silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) now <= '0;
        else      now <= now + TS_ONE;
    end

    // last_pins tracks live_pins even when the event is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_pins <= '0;
        else      last_pins <= live_pins;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {live_pins, now};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // A drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                overflow <= 1'b0;
        else if (drop)           overflow <= 1'b1;
        else if (clear_overflow) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_pin_change_capture.sv
// Directed bench for pin_change_capture: a 32-bit-timestamp build and an 8-bit
// build share the same stimulus; the 8-bit build covers timestamp wrap.
module tb_pin_change_capture;

    logic       clk;
    logic       rst;
    logic [7:0] pin_values;
    logic       ev_ready;
    logic       clear_overflow;

    logic [7:0]  ev_pins;
    logic [31:0] ev_time;
    logic        ev_valid;
    logic [4:0]  count;
    logic        overflow;
    logic [31:0] now;
    logic [7:0]  live_pins;

    logic [7:0]  ev_pins_8;
    logic [7:0]  ev_time_8;
    logic        ev_valid_8;
    logic [4:0]  count_8;
    logic        overflow_8;
    logic [7:0]  now_8;
    logic [7:0]  live_pins_8;

    int checks;
    int failures;
    int cyc;
    logic [39:0] exp_q[$];
    logic [39:0] exp_ev;
    logic [31:0] t;

    pin_change_capture #(.WIDTH(8), .TS_WIDTH(32), .DEPTH(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .pin_values(pin_values),
        .ev_pins(ev_pins), .ev_time(ev_time), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .count(count), .overflow(overflow), .clear_overflow(clear_overflow),
        .now(now), .live_pins(live_pins)
    );

    pin_change_capture #(.WIDTH(8), .TS_WIDTH(8), .DEPTH(16), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .pin_values(pin_values),
        .ev_pins(ev_pins_8), .ev_time(ev_time_8), .ev_valid(ev_valid_8), .ev_ready(ev_ready),
        .count(count_8), .overflow(overflow_8), .clear_overflow(clear_overflow),
        .now(now_8), .live_pins(live_pins_8)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One active edge, then settle; cyc mirrors the expected timestamp.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) cyc++;
    endtask

    task automatic pop_one();
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        exp_ev = exp_q.pop_front();
        check({tag, "_valid"}, 64'(ev_valid), 64'd1);
        check({tag, "_pins"}, 64'(ev_pins), 64'(exp_ev[39:32]));
        check({tag, "_time"}, 64'(ev_time), 64'(exp_ev[31:0]));
        pop_one();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        rst = 1'b0;
        pin_values = 8'hD2;
        ev_ready = 1'b0;
        clear_overflow = 1'b0;

        // Reset values
        #12;
        check("rst_valid", 64'(ev_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_now", 64'(now), 64'd0);
        check("rst_live", 64'(live_pins), 64'd0);
        check("rst_now8", 64'(now_8), 64'd0);

        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        tick();
        check("rel_now1", 64'(now), 64'd1);
        check("rel_live_e1", 64'(live_pins), 64'd0);
        tick();
        check("rel_live_e2", 64'(live_pins), 64'hD2);
        check("rel_count_e2", 64'(count), 64'd0);
        tick();
        check("rel_count", 64'(count), 64'd1);
        check("rel_pins", 64'(ev_pins), 64'hD2);
        check("rel_time", 64'(ev_time), 64'd2);
        check("rel_now3", 64'(now), 64'd3);
        pop_one();
        check("rel_pop_count", 64'(count), 64'd0);
        check("rel_pop_valid", 64'(ev_valid), 64'd0);

        // Single change latency
        t = 32'(cyc);
        pin_values = 8'h2D;
        tick();
        tick();
        check("lat_not_yet", 64'(ev_valid), 64'd0);
        tick();
        check("lat_valid", 64'(ev_valid), 64'd1);
        check("lat_pins", 64'(ev_pins), 64'h2D);
        check("lat_time", 64'(ev_time), 64'(t + 32'd2));
        pop_one();
        check("lat_pop_count", 64'(count), 64'd0);

        // Back-to-back changes
        t = 32'(cyc);
        for (int i = 0; i < 3; i++) begin
            pin_values = 8'(i + 1);
            exp_q.push_back({8'(i + 1), t + 32'(i) + 32'd2});
            tick();
        end
        tick();
        tick();
        check("b2b_count", 64'(count), 64'd3);
        for (int i = 0; i < 3; i++) pop_check("b2b");
        check("b2b_empty", 64'(count), 64'd0);

        // Fill plus one: the 17th event is dropped
        t = 32'(cyc);
        for (int i = 0; i < 17; i++) begin
            pin_values = 8'h10 + 8'(i);
            if (i < 16) exp_q.push_back({8'h10 + 8'(i), t + 32'(i) + 32'd2});
            tick();
        end
        tick();
        tick();
        check("full_count", 64'(count), 64'd16);
        check("full_overflow", 64'(overflow), 64'd1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("clr_overflow", 64'(overflow), 64'd0);

        // Change detected on the same edge as a pop while full
        t = 32'(cyc);
        pin_values = 8'h40;
        tick();
        tick();
        exp_ev = exp_q.pop_front();
        check("fpop_head_pins", 64'(ev_pins), 64'(exp_ev[39:32]));
        check("fpop_head_time", 64'(ev_time), 64'(exp_ev[31:0]));
        pop_one();
        exp_q.push_back({8'h40, t + 32'd2});
        check("fpop_count", 64'(count), 64'd16);
        check("fpop_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 16; i++) pop_check("fpop");
        check("fpop_empty", 64'(ev_valid), 64'd0);

        // Timestamp wrap on the 8-bit build
        for (int k = 0; k < 300 && cyc[7:0] != 8'hFD; k++) tick();
        check("wrap_align", 64'(now_8), 64'hFD);
        pin_values = 8'h55;
        tick();
        tick();
        pin_values = 8'hAA;
        tick();
        tick();
        tick();
        check("wrap_count", 64'(count_8), 64'd2);
        check("wrap_pins0", 64'(ev_pins_8), 64'h55);
        check("wrap_time0", 64'(ev_time_8), 64'hFF);
        pop_one();
        check("wrap_pins1", 64'(ev_pins_8), 64'hAA);
        check("wrap_time1", 64'(ev_time_8), 64'h01);
        pop_one();
        check("wrap_empty", 64'(ev_valid_8), 64'd0);

        // Asynchronous reset with five events pending
        for (int i = 0; i < 5; i++) begin
            pin_values = 8'h60 + 8'(i);
            tick();
        end
        tick();
        tick();
        check("mid_count", 64'(count), 64'd5);
        #2;
        rst = 1'b0;
        #1;
        cyc = 0;
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_valid", 64'(ev_valid), 64'd0);
        check("mid_rst_now", 64'(now), 64'd0);
        check("mid_rst_count8", 64'(count_8), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        tick();
        tick();
        check("post_rst_count", 64'(count), 64'd1);
        check("post_rst_pins", 64'(ev_pins), 64'h64);
        check("post_rst_time", 64'(ev_time), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
